// File: rtl/cve2_instr_mem_responder.sv
// Instruction-side fetch responder: grants word-aligned fetches after a configurable wait,
// reads a 1-cycle synchronous memory and returns in-order responses after a fixed latency.
module cve2_instr_mem_responder #(
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int          MemAddrWidth   = 10,
    parameter int          GntWaitCycles  = 0,
    parameter int          RvalidDelay    = 2,
    parameter int          MaxOutstanding = 2,
    localparam int         OutW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    instr_req_i,
    input  logic [31:0]             instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [31:0]             instr_rdata_o,
    output logic                    instr_err_o,
    input  logic                    gnt_stall_i,
    output logic                    mem_req_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    input  logic [31:0]             mem_rdata_i,
    output logic [OutW-1:0]         outstanding_o
);

    localparam logic [3:0]      GntWait = 4'(GntWaitCycles);
    localparam logic [OutW-1:0] MaxOut  = OutW'(MaxOutstanding);
    localparam int              Last    = RvalidDelay - 1;

    if ((GntWaitCycles < 0) || (GntWaitCycles > 15)) begin : g_bad_gnt_wait
        $error("GntWaitCycles must be in 0..15");
    end
    if ((RvalidDelay < 2) || (RvalidDelay > 8)) begin : g_bad_rvalid_delay
        $error("RvalidDelay must be in 2..8");
    end
    if ((MaxOutstanding < 1) || (MaxOutstanding > 8)) begin : g_bad_max_out
        $error("MaxOutstanding must be in 1..8");
    end
    if ((MemAddrWidth < 1) || (MemAddrWidth > 29)) begin : g_bad_mem_width
        $error("MemAddrWidth must be in 1..29");
    end

    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [OutW-1:0] outstanding_q, outstanding_d;
    logic            stg_valid_q [RvalidDelay];
    logic            stg_err_q   [RvalidDelay];
    logic [31:0]     stg_data_q  [1:RvalidDelay-1];

    logic [31:0]             offset_s;
    logic                    in_range_s;
    logic                    aligned_s;
    logic                    bad_s;
    logic                    wait_done_s;
    logic                    credit_s;
    logic                    gnt_s;
    logic                    accept_s;
    logic                    mem_req_s;
    logic [MemAddrWidth-1:0] mem_addr_s;
    logic                    rvalid_s;

    // Address decode, grant qualification and the memory strobe of the accept cycle
    always_comb begin
        offset_s    = instr_addr_i - BaseAddr;
        in_range_s  = ((offset_s >> (MemAddrWidth + 2)) == 32'h0);
        aligned_s   = (instr_addr_i[1:0] == 2'b00);
        bad_s       = ~in_range_s | ~aligned_s;
        wait_done_s = (wait_cnt_q >= GntWait);
        // Credit is judged on the registered count only; a retire this cycle frees it next cycle.
        credit_s    = (outstanding_q < MaxOut);
        gnt_s       = instr_req_i & wait_done_s & ~gnt_stall_i & credit_s;
        accept_s    = instr_req_i & gnt_s;
        mem_req_s   = accept_s & ~bad_s;
        if (mem_req_s) begin
            mem_addr_s = offset_s[MemAddrWidth+1:2];
        end else begin
            mem_addr_s = {MemAddrWidth{1'b0}};
        end
    end

    assign rvalid_s = stg_valid_q[Last];

    // Saturating grant-wait counter next state
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!instr_req_i || gnt_s) begin
            wait_cnt_d = 4'h0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'h1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Outstanding transaction count next state
    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept_s, rvalid_s})
            2'b10:   outstanding_d = outstanding_q + OutW'(1);
            2'b01:   outstanding_d = outstanding_q - OutW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Wait counter and outstanding count registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_cnt_q    <= 4'h0;
            outstanding_q <= {OutW{1'b0}};
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Fixed-latency response shift register; stage 1 picks up the memory data
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < RvalidDelay; k++) begin
                stg_valid_q[k] <= 1'b0;
                stg_err_q[k]   <= 1'b0;
            end
            for (int k = 1; k < RvalidDelay; k++) begin
                stg_data_q[k] <= 32'h0;
            end
        end else begin
            stg_valid_q[0] <= accept_s;
            stg_err_q[0]   <= accept_s & bad_s;
            for (int k = 1; k < RvalidDelay; k++) begin
                stg_valid_q[k] <= stg_valid_q[k-1];
                stg_err_q[k]   <= stg_err_q[k-1];
                if (k == 1) begin
                    stg_data_q[k] <= (stg_valid_q[0] && !stg_err_q[0]) ? mem_rdata_i : 32'h0;
                end else begin
                    stg_data_q[k] <= stg_data_q[k-1];
                end
            end
        end
    end

    // Invalid stages always carry zero err/data, so the last stage drives the bus directly.
    assign instr_gnt_o    = gnt_s;
    assign instr_rvalid_o = rvalid_s;
    assign instr_err_o    = stg_err_q[Last];
    assign instr_rdata_o  = stg_data_q[Last];
    assign mem_req_o      = mem_req_s;
    assign mem_addr_o     = mem_addr_s;
    assign outstanding_o  = outstanding_q;

    cve2_instr_mem_responder_chk #(
        .MaxOutstanding(MaxOutstanding),
        .OutW          (OutW)
    ) u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rvalid_i      (rvalid_s),
        .outstanding_i (outstanding_q)
    );

endmodule

// Invariant checks on the outstanding count of the fetch responder.
module cve2_instr_mem_responder_chk #(
    parameter int MaxOutstanding = 2,
    parameter int OutW           = 2
) (
    input logic            clk_i,
    input logic            rst_ni,
    input logic            rvalid_i,
    input logic [OutW-1:0] outstanding_i
);

    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    a_out_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_i <= MaxOut)
        else $error("outstanding count above limit");

    a_rvalid_has_txn: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rvalid_i |-> (outstanding_i != {OutW{1'b0}}))
        else $error("rvalid with no outstanding transaction");

endmodule

// File: tb/tb_cve2_instr_mem_responder.sv
// Bench for the fetch responder: four parameterisations share one clock; a vector table
// drives the default instance and short hand sequences cover wait, credit and burst cases.
module tb_cve2_instr_mem_responder;

    localparam int GW_P [4] = '{0, 3, 0, 0};
    localparam int RD_P [4] = '{2, 2, 4, 2};
    localparam int MO_P [4] = '{2, 2, 2, 3};
    localparam int NV = 26;

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        stall;
        logic        gnt;
        logic        mreq;
        logic [9:0]  maddr;
        logic        rv;
        logic [31:0] rd;
        logic        err;
        logic [1:0]  outs;
    } vec_t;

    logic        clk;
    logic        rst_n_s [4];
    logic        req_s   [4];
    logic        stall_s [4];
    logic [31:0] addr_s  [4];
    logic        gnt_s   [4];
    logic        rv_s    [4];
    logic [31:0] rd_s    [4];
    logic        err_s   [4];
    logic        mreq_s  [4];
    logic [9:0]  maddr_s [4];
    logic [31:0] mrd_s   [4];
    logic [1:0]  outs_s  [4];

    int   total;
    int   bad;
    vec_t vecs [NV];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        cve2_instr_mem_responder #(
            .GntWaitCycles (GW_P[g]),
            .RvalidDelay   (RD_P[g]),
            .MaxOutstanding(MO_P[g])
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n_s[g]),
            .instr_req_i   (req_s[g]),
            .instr_addr_i  (addr_s[g]),
            .instr_gnt_o   (gnt_s[g]),
            .instr_rvalid_o(rv_s[g]),
            .instr_rdata_o (rd_s[g]),
            .instr_err_o   (err_s[g]),
            .gnt_stall_i   (stall_s[g]),
            .mem_req_o     (mreq_s[g]),
            .mem_addr_o    (maddr_s[g]),
            .mem_rdata_i   (mrd_s[g]),
            .outstanding_o (outs_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] w);
        return (w == 32'd5) ? 32'hDEAD_BEEF : (32'h1000_0000 | w);
    endfunction

    // Synchronous memory model, one per instance
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mreq_s[k]) mrd_s[k] <= mem_word({22'h0, maddr_s[k]});
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic req, input logic [31:0] addr,
                                input logic stall, input logic gnt, input logic mreq,
                                input logic [9:0] maddr, input logic rv, input logic [31:0] rd,
                                input logic err, input logic [1:0] outs);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.stall = stall;
        v.gnt = gnt; v.mreq = mreq; v.maddr = maddr; v.rv = rv;
        v.rd = rd; v.err = err; v.outs = outs;
        return v;
    endfunction

    // Holds a request on instance d for nreq fetches from word wbase; checks per-cycle masks.
    task automatic run_seq(input int d, input int nreq, input int ncyc, input logic [15:0] gm,
                           input logic [15:0] vm, input int wbase);
        int ng;
        int nv;
        ng = 0;
        nv = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            req_s[d]  = (ng < nreq);
            addr_s[d] = 32'(4 * (wbase + ng));
            #1;
            chk($sformatf("d%0d gnt c%0d", d, c), {31'h0, gnt_s[d]}, {31'h0, gm[c]});
            chk($sformatf("d%0d rvalid c%0d", d, c), {31'h0, rv_s[d]}, {31'h0, vm[c]});
            if (rv_s[d]) begin
                chk($sformatf("d%0d rdata c%0d", d, c), rd_s[d], mem_word(32'(wbase + nv)));
                nv++;
            end
            chk($sformatf("d%0d outs bound c%0d", d, c),
                {31'h0, (32'(outs_s[d]) <= 32'(MO_P[d]))}, 32'h1);
            if (gnt_s[d]) ng++;
        end
        req_s[d] = 1'b0;
        @(negedge clk);
        #1;
        chk($sformatf("d%0d responses", d), 32'(nv), 32'($countones(vm)));
        chk($sformatf("d%0d outs idle", d), {30'h0, outs_s[d]}, 32'h0);
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;
        for (int k = 0; k < 4; k++) begin
            rst_n_s[k] = 1'b0;
            req_s[k]   = 1'b0;
            stall_s[k] = 1'b0;
            addr_s[k]  = 32'h0;
        end

        //             rst  req  addr          stl  gnt  mrq  madr   rv   rdata          err  outs
        vecs[0]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[1]  = mk(1'b1, 1'b1, 32'h0000_0014, 1'b0, 1'b1, 1'b1, 10'd5, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd1);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'd1);
        vecs[4]  = mk(1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[5]  = mk(1'b1, 1'b1, 32'h0000_0006, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd1);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'h0000_0000, 1'b1, 2'd2);
        vecs[7]  = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'h0000_0000, 1'b1, 2'd1);
        vecs[8]  = mk(1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[9]  = mk(1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 10'd1, 1'b0, 32'h0000_0000, 1'b0, 2'd1);
        vecs[10] = mk(1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'h1000_0000, 1'b0, 2'd2);
        vecs[11] = mk(1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 10'd2, 1'b1, 32'h1000_0001, 1'b0, 2'd1);
        vecs[12] = mk(1'b1, 1'b1, 32'h0000_000C, 1'b0, 1'b1, 1'b1, 10'd3, 1'b0, 32'h0000_0000, 1'b0, 2'd1);
        vecs[13] = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'h1000_0002, 1'b0, 2'd2);
        vecs[14] = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'h1000_0003, 1'b0, 2'd1);
        vecs[15] = mk(1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[16] = mk(1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[17] = mk(1'b1, 1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b1, 10'd1, 1'b0, 32'h0000_0000, 1'b0, 2'd1);
        vecs[18] = mk(1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'h1000_0000, 1'b0, 2'd2);
        vecs[19] = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[20] = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[21] = mk(1'b1, 1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[22] = mk(1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b1, 1'b1, 10'd2, 1'b0, 32'h0000_0000, 1'b0, 2'd0);
        vecs[23] = mk(1'b1, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd1);
        vecs[24] = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 32'h1000_0002, 1'b0, 2'd1);
        vecs[25] = mk(1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0000_0000, 1'b0, 2'd0);

        repeat (2) @(negedge clk);
        for (int k = 1; k < 4; k++) rst_n_s[k] = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(negedge clk);
            rst_n_s[0] = v.rst;
            req_s[0]   = v.req;
            addr_s[0]  = v.addr;
            stall_s[0] = v.stall;
            #1;
            chk($sformatf("v%0d gnt", i),    {31'h0, gnt_s[0]},   {31'h0, v.gnt});
            chk($sformatf("v%0d mem_req", i), {31'h0, mreq_s[0]},  {31'h0, v.mreq});
            chk($sformatf("v%0d mem_addr", i), {22'h0, maddr_s[0]}, {22'h0, v.maddr});
            chk($sformatf("v%0d rvalid", i), {31'h0, rv_s[0]},    {31'h0, v.rv});
            chk($sformatf("v%0d rdata", i),  rd_s[0],             v.rd);
            chk($sformatf("v%0d err", i),    {31'h0, err_s[0]},   {31'h0, v.err});
            chk($sformatf("v%0d outs", i),   {30'h0, outs_s[0]},  {30'h0, v.outs});
        end
        req_s[0] = 1'b0;

        run_seq(1, 2, 11, 16'h0088, 16'h0220, 5);
        run_seq(2, 3, 11, 16'h0023, 16'h0230, 0);
        run_seq(3, 4, 7,  16'h000F, 16'h003C, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
